rgmii_rx_dly_cal: RTL and testbench

RGMII_RX_DLY_CAL -- requirements
Module: rgmii_rx_dly_cal

---
 rtl/rgmii_cal_pkg.sv | 27 ++
 rtl/rgmii_pre_chk.sv | 96 +++++++++
 rtl/rgmii_rx_dly_cal.sv | 242 ++++++++++++++++++++++++
 tb/tb_rgmii_rx_dly_cal.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_cal_pkg.sv
// Shared definitions for the RGMII receive delay calibrator: FSM states,
// preamble/SFD byte values and the minimum preamble length that counts as good.
package rgmii_cal_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_SETTLE   = 4'd2,
        ST_WAIT_GAP = 4'd3,
        ST_CHECK    = 4'd4,
        ST_NEXT     = 4'd5,
        ST_SEARCH   = 4'd6,
        ST_APPLY    = 4'd7,
        ST_DONE     = 4'd8
    } cal_state_e;

    typedef enum logic [1:0] {
        JUDGE_IDLE = 2'd0,
        JUDGE_PRE  = 2'd1,
        JUDGE_SKIP = 2'd2
    } judge_state_e;

    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam int unsigned MIN_PRE_LEN = 6;

endpackage

// File: rtl/rgmii_pre_chk.sv
// Per-frame preamble judge: emits a one-cycle good or bad pulse for each frame
// that starts while enabled. Disabling it returns it to the idle state.
module rgmii_pre_chk
    import rgmii_cal_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_dv,
    input  logic [7:0] rxd,
    output logic       good,
    output logic       bad
);

    localparam logic [2:0] PRE_SAT = 3'(MIN_PRE_LEN);

    judge_state_e state_r, state_next_s;
    logic [2:0]   pre_cnt_r, pre_cnt_next_s;
    logic         good_r, good_next_s;
    logic         bad_r, bad_next_s;

    // Frame judging; the preamble count saturates once it reaches the minimum length
    always_comb begin
        state_next_s   = state_r;
        pre_cnt_next_s = pre_cnt_r;
        good_next_s    = 1'b0;
        bad_next_s     = 1'b0;
        if (!en) begin
            state_next_s   = JUDGE_IDLE;
            pre_cnt_next_s = 3'd0;
        end else begin
            case (state_r)
                JUDGE_IDLE: begin
                    if (rx_dv && (rxd == PRE_BYTE)) begin
                        state_next_s   = JUDGE_PRE;
                        pre_cnt_next_s = 3'd1;
                    end else if (rx_dv) begin
                        state_next_s = JUDGE_SKIP;
                        bad_next_s   = 1'b1;
                    end else begin
                        state_next_s = JUDGE_IDLE;
                    end
                end
                JUDGE_PRE: begin
                    if (!rx_dv) begin
                        state_next_s = JUDGE_IDLE;
                        bad_next_s   = 1'b1;
                    end else if (rxd == PRE_BYTE) begin
                        if (pre_cnt_r < PRE_SAT) begin
                            pre_cnt_next_s = pre_cnt_r + 3'd1;
                        end else begin
                            pre_cnt_next_s = pre_cnt_r;
                        end
                    end else if (rxd == SFD_BYTE) begin
                        state_next_s = JUDGE_SKIP;
                        good_next_s  = (pre_cnt_r >= PRE_SAT);
                        bad_next_s   = (pre_cnt_r < PRE_SAT);
                    end else begin
                        state_next_s = JUDGE_SKIP;
                        bad_next_s   = 1'b1;
                    end
                end
                JUDGE_SKIP: begin
                    if (!rx_dv) begin
                        state_next_s = JUDGE_IDLE;
                    end else begin
                        state_next_s = JUDGE_SKIP;
                    end
                end
                default: begin
                    state_next_s   = JUDGE_IDLE;
                    pre_cnt_next_s = 3'd0;
                end
            endcase
        end
    end

    // Judge state and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= JUDGE_IDLE;
            pre_cnt_r <= 3'd0;
            good_r    <= 1'b0;
            bad_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pre_cnt_r <= pre_cnt_next_s;
            good_r    <= good_next_s;
            bad_r     <= bad_next_s;
        end
    end

    assign good = good_r;
    assign bad  = bad_r;

endmodule

// File: rtl/rgmii_rx_dly_cal.sv
// RGMII receive delay calibrator: sweeps all 32 IDELAY taps, judges preambles
// at each tap, then applies the centre of the longest passing window.
module rgmii_rx_dly_cal
    import rgmii_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned PASS_FRAMES = 4,
    parameter int unsigned TIMEOUT_CYC = 1048576,
    parameter int unsigned DEFAULT_TAP = 0
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        cal_start,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        dly_ld,
    output logic [4:0]  dly_cntvalue,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_err,
    output logic [31:0] pass_map,
    output logic [4:0]  best_tap
);

    localparam logic [4:0]  DEF_TAP      = 5'(DEFAULT_TAP);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  GOOD_LAST    = 8'(PASS_FRAMES - 1);

    cal_state_e  state_r, state_next_s;
    logic [4:0]  tap_r, tap_next_s;
    logic [31:0] cnt_r, cnt_next_s;
    logic [7:0]  good_cnt_r, good_cnt_next_s;
    logic [31:0] pass_map_r, pass_map_next_s;
    logic [4:0]  scan_idx_r, scan_idx_next_s;
    logic [4:0]  run_start_r, run_start_next_s, run_start_s;
    logic [5:0]  run_len_r, run_len_next_s, run_len_s;
    logic [4:0]  best_start_r, best_start_next_s, best_start_s;
    logic [5:0]  best_len_r, best_len_next_s, best_len_s;
    logic [4:0]  best_tap_r, best_tap_next_s;
    logic        cal_busy_r, cal_busy_next_s;
    logic        cal_done_r, cal_done_next_s;
    logic        cal_err_r, cal_err_next_s;
    logic        dly_ld_r, dly_ld_next_s;
    logic [4:0]  dly_cntvalue_r, dly_cntvalue_next_s;
    logic        chk_good_s, chk_bad_s;

    rgmii_pre_chk u_pre_chk (
        .clk   (gmii_rx_clk),
        .rst   (rst),
        .en    (state_r == ST_CHECK),
        .rx_dv (gmii_rx_dv),
        .rxd   (gmii_rxd),
        .good  (chk_good_s),
        .bad   (chk_bad_s)
    );

    // Streaming run-length step for the pass_map bit under the scan index; strict > keeps the lowest start on ties
    always_comb begin
        run_start_s  = run_start_r;
        run_len_s    = 6'd0;
        best_start_s = best_start_r;
        best_len_s   = best_len_r;
        if (pass_map_r[scan_idx_r]) begin
            run_start_s = (run_len_r == 6'd0) ? scan_idx_r : run_start_r;
            run_len_s   = run_len_r + 6'd1;
        end else begin
            run_start_s = run_start_r;
            run_len_s   = 6'd0;
        end
        if (run_len_s > best_len_r) begin
            best_start_s = run_start_s;
            best_len_s   = run_len_s;
        end else begin
            best_start_s = best_start_r;
            best_len_s   = best_len_r;
        end
    end

    // Next-state and next-output logic for the calibration sequencer
    always_comb begin
        state_next_s      = state_r;
        tap_next_s        = tap_r;
        cnt_next_s        = cnt_r;
        good_cnt_next_s   = good_cnt_r;
        pass_map_next_s   = pass_map_r;
        scan_idx_next_s   = scan_idx_r;
        run_start_next_s  = run_start_r;
        run_len_next_s    = run_len_r;
        best_start_next_s = best_start_r;
        best_len_next_s   = best_len_r;
        best_tap_next_s   = best_tap_r;
        cal_busy_next_s   = cal_busy_r;
        cal_done_next_s   = cal_done_r;
        cal_err_next_s    = cal_err_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (cal_start) begin
                    state_next_s    = ST_LOAD;
                    tap_next_s      = 5'd0;
                    pass_map_next_s = 32'd0;
                    cal_busy_next_s = 1'b1;
                    cal_done_next_s = 1'b0;
                    cal_err_next_s  = 1'b0;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_SETTLE;
                cnt_next_s   = 32'd0;
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_WAIT_GAP;
                end else begin
                    cnt_next_s = cnt_r + 32'd1;
                end
            end
            ST_WAIT_GAP: begin
                if (!gmii_rx_dv) begin
                    state_next_s    = ST_CHECK;
                    cnt_next_s      = 32'd0;
                    good_cnt_next_s = 8'd0;
                end else begin
                    state_next_s = ST_WAIT_GAP;
                end
            end
            ST_CHECK: begin
                cnt_next_s = cnt_r + 32'd1;
                if (chk_good_s && (good_cnt_r == GOOD_LAST)) begin
                    pass_map_next_s = pass_map_r | (32'd1 << tap_r);
                    state_next_s    = ST_NEXT;
                end else if (chk_bad_s || (cnt_r == TIMEOUT_LAST)) begin
                    state_next_s = ST_NEXT;
                end else if (chk_good_s) begin
                    good_cnt_next_s = good_cnt_r + 8'd1;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_NEXT: begin
                if (tap_r == 5'd31) begin
                    state_next_s      = ST_SEARCH;
                    scan_idx_next_s   = 5'd0;
                    run_start_next_s  = 5'd0;
                    run_len_next_s    = 6'd0;
                    best_start_next_s = 5'd0;
                    best_len_next_s   = 6'd0;
                end else begin
                    state_next_s = ST_LOAD;
                    tap_next_s   = tap_r + 5'd1;
                end
            end
            ST_SEARCH: begin
                scan_idx_next_s   = scan_idx_r + 5'd1;
                run_start_next_s  = run_start_s;
                run_len_next_s    = run_len_s;
                best_start_next_s = best_start_s;
                best_len_next_s   = best_len_s;
                if (scan_idx_r == 5'd31) begin
                    state_next_s = ST_APPLY;
                    if (best_len_s == 6'd0) begin
                        best_tap_next_s = DEF_TAP;
                    end else begin
                        best_tap_next_s = best_start_s + 5'((best_len_s - 6'd1) >> 1);
                    end
                end else begin
                    state_next_s = ST_SEARCH;
                end
            end
            ST_APPLY: begin
                state_next_s    = ST_DONE;
                cal_busy_next_s = 1'b0;
                cal_done_next_s = (best_len_r != 6'd0);
                cal_err_next_s  = (best_len_r == 6'd0);
            end
            default: begin
                state_next_s    = ST_IDLE;
                cal_busy_next_s = 1'b0;
            end
        endcase

        // The load strobe and its value are registered together from the upcoming state
        dly_ld_next_s = (state_next_s == ST_LOAD) || (state_next_s == ST_APPLY);
        if (state_next_s == ST_LOAD) begin
            dly_cntvalue_next_s = tap_next_s;
        end else if (state_next_s == ST_APPLY) begin
            dly_cntvalue_next_s = best_tap_next_s;
        end else begin
            dly_cntvalue_next_s = dly_cntvalue_r;
        end
    end

    // State and output registers
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            tap_r          <= 5'd0;
            cnt_r          <= 32'd0;
            good_cnt_r     <= 8'd0;
            pass_map_r     <= 32'd0;
            scan_idx_r     <= 5'd0;
            run_start_r    <= 5'd0;
            run_len_r      <= 6'd0;
            best_start_r   <= 5'd0;
            best_len_r     <= 6'd0;
            best_tap_r     <= DEF_TAP;
            cal_busy_r     <= 1'b0;
            cal_done_r     <= 1'b0;
            cal_err_r      <= 1'b0;
            dly_ld_r       <= 1'b0;
            dly_cntvalue_r <= DEF_TAP;
        end else begin
            state_r        <= state_next_s;
            tap_r          <= tap_next_s;
            cnt_r          <= cnt_next_s;
            good_cnt_r     <= good_cnt_next_s;
            pass_map_r     <= pass_map_next_s;
            scan_idx_r     <= scan_idx_next_s;
            run_start_r    <= run_start_next_s;
            run_len_r      <= run_len_next_s;
            best_start_r   <= best_start_next_s;
            best_len_r     <= best_len_next_s;
            best_tap_r     <= best_tap_next_s;
            cal_busy_r     <= cal_busy_next_s;
            cal_done_r     <= cal_done_next_s;
            cal_err_r      <= cal_err_next_s;
            dly_ld_r       <= dly_ld_next_s;
            dly_cntvalue_r <= dly_cntvalue_next_s;
        end
    end

    assign dly_ld       = dly_ld_r;
    assign dly_cntvalue = dly_cntvalue_r;
    assign cal_busy     = cal_busy_r;
    assign cal_done     = cal_done_r;
    assign cal_err      = cal_err_r;
    assign pass_map     = pass_map_r;
    assign best_tap     = best_tap_r;

endmodule

// File: tb/tb_rgmii_rx_dly_cal.sv
// Self-checking bench: a PHY-like frame source sends good preambles only at the
// taps in a chosen pass set; results are compared against a window-search model.
module tb_rgmii_rx_dly_cal;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned PASSN  = 4;
    localparam int unsigned TMO    = 64;
    localparam int unsigned DEF    = 9;

    localparam int MODE_RAND  = 0;
    localparam int MODE_GOOD7 = 1;
    localparam int MODE_BAD54 = 2;
    localparam int MODE_QUIET = 3;
    localparam int MODE_LATE  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cal_start = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        dly_ld;
    logic [4:0]  dly_cntvalue;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_err;
    logic [31:0] pass_map;
    logic [4:0]  best_tap;

    int          checks = 0;
    int          failures = 0;
    int          mode = MODE_RAND;
    logic [31:0] good_mask = 32'd0;
    int          cyc = 0;
    logic [4:0]  ld_val_q[$];
    int          ld_cyc_q[$];
    logic [4:0]  cur_tap = 5'd0;

    always #4 clk = ~clk;

    rgmii_rx_dly_cal #(
        .SETTLE_CYC  (SETTLE),
        .PASS_FRAMES (PASSN),
        .TIMEOUT_CYC (TMO),
        .DEFAULT_TAP (DEF)
    ) dut (
        .gmii_rx_clk  (clk),
        .rst          (rst),
        .cal_start    (cal_start),
        .gmii_rx_dv   (dv),
        .gmii_rxd     (rxd),
        .dly_ld       (dly_ld),
        .dly_cntvalue (dly_cntvalue),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_err      (cal_err),
        .pass_map     (pass_map),
        .best_tap     (best_tap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Centre of the longest run of ones, lowest start on ties; DEF when empty
    function automatic logic [4:0] model_best(input logic [31:0] m);
        int bl, bs, l;
        bl = 0;
        bs = 0;
        for (int s = 0; s < 32; s++) begin
            l = 0;
            while ((s + l) < 32 && m[s + l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
        if (bl == 0) return 5'(DEF);
        return 5'(bs + (bl - 1) / 2);
    endfunction

    // Frame source: the delay setting decides whether the receiver sees clean preambles
    initial begin : gen
        logic [7:0] q[$];
        int gap, n, k, pay;
        gap = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (dly_ld) begin
                cur_tap = dly_cntvalue;
                ld_val_q.push_back(dly_cntvalue);
                ld_cyc_q.push_back(cyc);
                if (mode == MODE_LATE) begin
                    q.delete();
                    for (int i = 0; i < 24; i++) q.push_back(8'h54);
                    gap = 0;
                end
            end
            if (mode == MODE_QUIET) begin
                q.delete();
                gap = 0;
                dv = 1'b0;
                rxd = 8'h00;
            end else begin
                if (q.size() == 0 && gap == 0) begin
                    if (good_mask[cur_tap]) begin
                        n = (mode == MODE_GOOD7) ? 7 : int'($urandom_range(7, 6));
                        for (int i = 0; i < n; i++) q.push_back(8'h55);
                        q.push_back(8'hD5);
                        pay = $urandom_range(2, 1);
                        for (int i = 0; i < pay; i++) q.push_back(8'($urandom));
                    end else begin
                        k = (mode == MODE_BAD54) ? 0 : int'($urandom_range(2, 0));
                        for (int i = 0; i < 3; i++) q.push_back(8'h55);
                        if (k == 0) begin
                            q.push_back(8'h54);
                            for (int i = 0; i < 3; i++) q.push_back(8'h55);
                            q.push_back(8'hD5);
                        end else if (k == 1) begin
                            q.push_back(8'hD5);
                        end else begin
                            q.push_back(8'h55);
                        end
                    end
                end
                if (q.size() > 0) begin
                    dv = 1'b1;
                    rxd = q.pop_front();
                    if (q.size() == 0) gap = $urandom_range(3, 1);
                end else begin
                    dv = 1'b0;
                    rxd = 8'h00;
                    if (gap > 0) gap--;
                end
            end
        end
    end

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ld"}, 32'(dly_ld), 32'd0);
        check({pfx, "_cntvalue"}, 32'(dly_cntvalue), DEF);
        check({pfx, "_busy"}, 32'(cal_busy), 32'd0);
        check({pfx, "_done"}, 32'(cal_done), 32'd0);
        check({pfx, "_err"}, 32'(cal_err), 32'd0);
        check({pfx, "_pass_map"}, pass_map, 32'd0);
        check({pfx, "_best_tap"}, 32'(best_tap), DEF);
    endtask

    task automatic run_cal(input string name, input logic [31:0] mask, input int md, input bit poke_busy);
        logic [31:0] exp_map;
        logic [4:0]  exp_best;
        int          t;
        bit          seq_ok;
        mode = md;
        good_mask = mask;
        exp_map = (md == MODE_QUIET) ? 32'd0 : mask;
        exp_best = model_best(exp_map);
        ld_val_q.delete();
        ld_cyc_q.delete();
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        check({name, "_busy_start"}, 32'(cal_busy), 32'd1);
        t = 0;
        if (poke_busy) begin
            repeat (300) tick();
            cal_start = 1'b1;
            tick();
            cal_start = 1'b0;
            t = 301;
        end
        while (!(cal_done || cal_err) && t < 20000) begin
            tick();
            t++;
        end
        check({name, "_in_time"}, 32'(t < 20000), 32'd1);
        tick();
        check({name, "_pass_map"}, pass_map, exp_map);
        check({name, "_best_tap"}, 32'(best_tap), 32'(exp_best));
        check({name, "_done"}, 32'(cal_done), 32'(exp_map != 32'd0));
        check({name, "_err"}, 32'(cal_err), 32'(exp_map == 32'd0));
        check({name, "_busy_end"}, 32'(cal_busy), 32'd0);
        check({name, "_final_cntvalue"}, 32'(dly_cntvalue), 32'(exp_best));
        check({name, "_ld_pulses"}, 32'(ld_val_q.size()), 32'd33);
        seq_ok = (ld_val_q.size() == 33);
        for (int i = 0; i < 32 && seq_ok; i++) seq_ok = (ld_val_q[i] == 5'(i));
        if (seq_ok) seq_ok = (ld_val_q[32] == exp_best);
        check({name, "_ld_sequence"}, 32'(seq_ok), 32'd1);
    endtask

    initial begin : watchdog
        #(8 * 150000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, n, iv;
        bit iv_ok;
        repeat (3) tick();
        check_reset_state("in_reset");
        rst = 1'b0;
        tick();
        check_reset_state("after_reset");

        run_cal("win10_20", 32'h001F_FC00, MODE_GOOD7, 1'b0);
        run_cal("tie", 32'h00F0_003C, MODE_RAND, 1'b1);
        run_cal("rand_a", $urandom, MODE_RAND, 1'b0);
        run_cal("bad54", 32'd0, MODE_BAD54, 1'b0);

        run_cal("quiet", 32'hFFFF_FFFF, MODE_QUIET, 1'b0);
        iv_ok = (ld_cyc_q.size() == 33);
        iv = 0;
        for (int i = 1; i < 32 && iv_ok; i++) begin
            iv = ld_cyc_q[i] - ld_cyc_q[i - 1];
            iv_ok = (iv >= int'(SETTLE + TMO)) && (iv <= int'(SETTLE + TMO + 4));
        end
        check("quiet_tap_interval_ok", 32'(iv_ok), 32'd1);

        run_cal("late_frame", 32'h0FF0_0F00, MODE_LATE, 1'b0);

        // Reset mid-calibration while tap 7 is being checked
        mode = MODE_RAND;
        good_mask = 32'hFFFF_FFFF;
        ld_val_q.delete();
        ld_cyc_q.delete();
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        t = 0;
        while (!(dly_ld && dly_cntvalue == 5'd7) && t < 5000) begin
            tick();
            t++;
        end
        check("rst_reach_tap7", 32'(t < 5000), 32'd1);
        repeat (33) tick();
        check("rst_pre_busy", 32'(cal_busy), 32'd1);
        check("rst_pre_map", pass_map, 32'h0000_007F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("mid_rst");
        n = ld_val_q.size();
        repeat (40) tick();
        check("mid_rst_no_ld", 32'(ld_val_q.size()), 32'(n));
        check("mid_rst_idle_busy", 32'(cal_busy), 32'd0);

        run_cal("rand_b", $urandom, MODE_RAND, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
